// File: rtl/sha_pkg.sv
// Shared SHA-1 / SHA-256 message-schedule definitions: mode encoding, round
// counts and the rotate/sigma bit functions used by the schedule datapath.
package sha_pkg;

   typedef enum logic {
      SHA_MODE_SHA1   = 1'b0,
      SHA_MODE_SHA256 = 1'b1
   } sha_mode_e;

   localparam int SHA1_ROUNDS   = 80;
   localparam int SHA256_ROUNDS = 64;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha_w_next.sv
// Combinational next-word generator: produces W[t+16] from the current
// 16-word window for SHA-1, or for SHA-256 when that path is built.
module sha_w_next
   import sha_pkg::*;
#(
   parameter int ENABLE_SHA256 = 1
) (
   input  logic [31:0] i_s0,
   input  logic [31:0] i_s1,
   input  logic [31:0] i_s2,
   input  logic [31:0] i_s8,
   input  logic [31:0] i_s9,
   input  logic [31:0] i_s13,
   input  logic [31:0] i_s14,
   input  sha_mode_e   i_mode,
   output logic [31:0] o_w_new
);

   logic [31:0] w_sha1;

   assign w_sha1 = rotl(i_s13 ^ i_s8 ^ i_s2 ^ i_s0, 1);

   generate
      if (ENABLE_SHA256 != 0) begin : g_sha256
         logic [31:0] w_sha256;
         assign w_sha256 = sigma1(i_s14) + i_s9 + sigma0(i_s1) + i_s0;
         assign o_w_new  = (i_mode == SHA_MODE_SHA256) ? w_sha256 : w_sha1;
      end else begin : g_sha1_only
         // SHA-256-only taps are intentionally left unconnected in this build.
         logic w_unused;
         assign w_unused = ^{i_s1, i_s9, i_s14, i_mode};
         assign o_w_new  = w_sha1;
      end
   endgenerate

endmodule

// File: rtl/sha_w_sched.sv
// SHA-1 / SHA-256 message schedule: accepts a 512-bit block and streams
// W[0..ROUNDS-1] one word per consumer 'next' from a sliding 16-word window.
module sha_w_sched
   import sha_pkg::*;
#(
   parameter int ENABLE_SHA256 = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [511:0] block,
   input  logic         block_valid,
   output logic         block_ready,
   input  logic         mode,
   input  logic         next,
   input  logic         abort,
   output logic [31:0]  w,
   output logic         w_valid,
   output logic [6:0]   w_idx,
   output logic         last
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [6:0] SHA1_LAST_IDX   = 7'(SHA1_ROUNDS - 1);
   localparam logic [6:0] SHA256_LAST_IDX = 7'(SHA256_ROUNDS - 1);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [31:0] r_win [16];
   logic [6:0]  r_t;
   sha_mode_e   r_mode;

   logic        w_accept;
   logic        w_last;
   logic        w_leave;
   logic        w_shift;
   logic [31:0] w_new;

   assign w_accept = (r_state == ST_IDLE) && block_valid && !abort;
   assign w_last   = (r_state == ST_RUN) &&
                     (r_t == ((r_mode == SHA_MODE_SHA256) ? SHA256_LAST_IDX : SHA1_LAST_IDX));
   assign w_leave  = (r_state == ST_RUN) && (abort || (next && w_last));
   assign w_shift  = (r_state == ST_RUN) && next && !abort && !w_last;

   sha_w_next #(
      .ENABLE_SHA256 (ENABLE_SHA256)
   ) u_w_next (
      .i_s0    (r_win[0]),
      .i_s1    (r_win[1]),
      .i_s2    (r_win[2]),
      .i_s8    (r_win[8]),
      .i_s9    (r_win[9]),
      .i_s13   (r_win[13]),
      .i_s14   (r_win[14]),
      .i_mode  (r_mode),
      .o_w_new (w_new)
   );

   always_comb begin
      // NOTE: assign the default before the case so no path leaves w_state_nxt unassigned (which would infer a latch).
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_leave)  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_t     <= '0;
         r_mode  <= SHA_MODE_SHA1;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_t    <= '0;
            r_mode <= ((ENABLE_SHA256 != 0) && mode) ? SHA_MODE_SHA256 : SHA_MODE_SHA1;
         end else if (w_leave) begin
            r_t <= '0;
         end else if (w_shift) begin
            r_t <= r_t + 7'd1;
         end
      end
   end

   // NOTE: the window is a register array that IS reset, because w must read 0 out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 16; k++) r_win[k] <= '0;
      end else if (w_accept) begin
         for (int k = 0; k < 16; k++) r_win[k] <= block[511 - 32*k -: 32];
      end else if (w_shift) begin
         for (int k = 0; k < 15; k++) r_win[k] <= r_win[k+1];
         r_win[15] <= w_new;
      end
   end

   assign block_ready = (r_state == ST_IDLE);
   assign w_valid     = (r_state == ST_RUN);
   assign w           = r_win[0];
   assign w_idx       = r_t;
   assign last        = w_last;

endmodule
